// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle of the PC sequencer: instruction-memory handshake plus
// the control/decode signals it exchanges each instruction.
interface pc_sequencer_if #(
  parameter int PC_W = 4
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic            stall;
  logic            branch;
  logic            zero;
  logic [PC_W-1:0] branch_target;
  logic            halt;
  logic [PC_W-1:0] pc;
  logic            issue;
  logic            br_taken;
  logic            halted;

  modport master (
    output imem_req, imem_addr, pc, issue, br_taken, halted,
    input  imem_ack, stall, branch, zero, branch_target, halt
  );

  modport slave (
    input  imem_req, imem_addr, pc, issue, br_taken, halted,
    output imem_ack, stall, branch, zero, branch_target, halt
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch sequencer: owns the PC, runs the imem req/ack handshake and picks
// the next PC (sequential step or taken branch) once per issued instruction.
module pc_sequencer #(
  parameter int PC_W     = 4,
  parameter int STEP     = 1,
  parameter int RESET_PC = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pc_sequencer_if.master       bus
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    EXEC,
    STALL,
    HALTED
  } state_t;

  localparam logic [1:0]      STEP2    = STEP[1:0];
  localparam logic [PC_W-1:0] STEP_EXT = PC_W'(STEP2);
  localparam logic [PC_W-1:0] PC_RST   = PC_W'(RESET_PC);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            update;
  logic            req;
  logic            issue;
  logic            br_taken;
  logic            halted;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= PC_RST;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    update   = 1'b0;
    req      = 1'b0;
    issue    = 1'b0;
    br_taken = 1'b0;
    halted   = 1'b0;

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        // halt is deliberately not looked at here: a request always completes
        req = 1'b1;
        if (bus.imem_ack) state_d = EXEC;
      end
      EXEC: begin
        issue = 1'b1;
        if (bus.halt) begin
          state_d = HALTED;
        end else if (bus.stall) begin
          state_d = STALL;
        end else begin
          update  = 1'b1;
          state_d = REQ;
        end
      end
      STALL: begin
        if (bus.halt) begin
          state_d = HALTED;
        end else if (!bus.stall) begin
          update  = 1'b1;
          state_d = REQ;
        end
      end
      HALTED: halted = 1'b1;
      default: state_d = IDLE;
    endcase

    // Branch inputs matter only in the cycle that actually moves the PC
    if (update) begin
      if (bus.branch && bus.zero) begin
        pc_d     = bus.branch_target;
        br_taken = 1'b1;
      end else begin
        pc_d = pc_q + STEP_EXT;
      end
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc_q;
  assign bus.pc        = pc_q;
  assign bus.issue     = issue;
  assign bus.br_taken  = br_taken;
  assign bus.halted    = halted;

endmodule
